rifl_tx_arbiter: RTL

- Shares the single 116-bit user-flit input of the RIFL TX core between NUM_CH independent requester channels.
- Performs round-robin, packet-aware arbitration. Stalls on the core's tx_ready and issues new grants only while the link reports tx_up.
- Sits directly in front of the RIFL TX core. The outputs tx_data/tx_valid connect to the core's data_in/valid_in; tx_ready/tx_up come back from the core.

---
 rtl/rifl_tx_arbiter_pkg.sv | 11 +
 rtl/rifl_tx_arbiter_if.sv | 23 ++
 rtl/rifl_tx_arbiter_rr_pick.sv | 22 ++
 rtl/rifl_tx_arbiter.sv | 83 ++++++++
 4 files changed

// File: rtl/rifl_tx_arbiter_pkg.sv
// rifl_tx_arbiter_pkg: shared state encoding, flit width and clog2 helper for the RIFL TX arbiter
package rifl_tx_arbiter_pkg;
  localparam int RIFL_FLIT_W = 116;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/rifl_tx_arbiter_if.sv
// rifl_tx_arbiter_if: requester channels plus TX core handshake seen by the arbiter
interface rifl_tx_arbiter_if import rifl_tx_arbiter_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DWIDTH = RIFL_FLIT_W
);
  logic [NUM_CH*DWIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_last;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH-1:0]        ch_en;
  logic [DWIDTH-1:0]        tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic                     tx_up;
  modport slave (
    input  ch_data, ch_valid, ch_last, ch_en, tx_ready, tx_up,
    output ch_ready, tx_data, tx_valid
  );
  modport master (
    output ch_data, ch_valid, ch_last, ch_en, tx_ready, tx_up,
    input  ch_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/rifl_tx_arbiter_rr_pick.sv
// rifl_tx_arbiter_rr_pick: first set request at or after ptr, cyclically
module rifl_tx_arbiter_rr_pick import rifl_tx_arbiter_pkg::*; #(
  parameter int N = 4,
  localparam int IW = clog2(N)
)(
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;
  assign rot = N'({req, req} >> ptr);
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) off = rot[i] ? IW'(i) : off;
  end
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign found = |req;
  assign idx = sum >= (IW+1)'(N) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
endmodule

// File: rtl/rifl_tx_arbiter.sv
// rifl_tx_arbiter: packet-aware round-robin arbiter feeding the RIFL TX core flit input
module rifl_tx_arbiter import rifl_tx_arbiter_pkg::*; #(
  parameter int NUM_CH    = 4,
  parameter int DWIDTH    = RIFL_FLIT_W,
  parameter int PKT_MODE  = 1,
  parameter int MAX_BURST = 64,
  parameter int CNT_W     = 32,
  localparam int IW = clog2(NUM_CH)
)(
  input  logic                    clk,
  input  logic                    rst,
  rifl_tx_arbiter_if.slave        bus,
  output logic                    grant_vld,
  output logic [IW-1:0]           grant_id,
  input  logic                    stat_clr,
  output logic [NUM_CH*CNT_W-1:0] stat_flits
);
  arb_state_e        state, state_n;
  logic [IW-1:0]     gid, gid_n, ptr, ptr_n, gnext, pick_ptr, pick_idx;
  logic [15:0]       bcnt, bcnt_n;
  logic [NUM_CH-1:0] req, pick_req, gmask;
  logic              act, xfer, rel, pick_found;
  assign req = bus.ch_valid & bus.ch_en;
  assign gmask = NUM_CH'(1) << gid;
  assign act = rst && state == GRANT;
  assign gnext = gid == IW'(NUM_CH - 1) ? '0 : gid + 1'b1;
  assign bus.tx_valid = act && bus.ch_valid[gid];
  assign bus.tx_data = act ? bus.ch_data[gid*DWIDTH +: DWIDTH] : '0;
  assign bus.ch_ready = act && bus.tx_ready ? gmask : '0;
  assign xfer = bus.tx_valid && bus.tx_ready;
  assign rel = xfer && (bus.ch_last[gid] || (PKT_MODE == 0 && bcnt == 16'(MAX_BURST - 1)));
  assign pick_req = state == GRANT ? req & ~gmask : req;
  assign pick_ptr = state == GRANT ? gnext : ptr;
  rifl_tx_arbiter_rr_pick #(.N(NUM_CH)) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      gid   <= '0;
      ptr   <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      gid   <= gid_n;
      ptr   <= ptr_n;
      bcnt  <= bcnt_n;
    end
  end
  always_comb begin
    state_n = state;
    gid_n   = gid;
    ptr_n   = ptr;
    bcnt_n  = bcnt;
    if (state == IDLE) begin
      if (bus.tx_up && pick_found) begin
        state_n = GRANT;
        gid_n   = pick_idx;
        bcnt_n  = '0;
      end
    end else if (rel) begin
      ptr_n  = gnext;
      bcnt_n = '0;
      state_n = bus.tx_up && pick_found ? GRANT : IDLE;
      gid_n   = bus.tx_up && pick_found ? pick_idx : gid;
    end else if (xfer) begin
      bcnt_n = bcnt + 1'b1;
    end
  end
  assign grant_vld = state == GRANT;
  assign grant_id  = gid;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_stat
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (!rst || stat_clr) cnt <= '0;
      else if (xfer && gid == IW'(c) && cnt != '1) cnt <= cnt + 1'b1;
    end
    assign stat_flits[c*CNT_W +: CNT_W] = cnt;
  end
endmodule
